// File: rtl/pe_row_feeder.sv
// pe_row_feeder: fetches one filter row and one ifmap row from the
// scratchpad and streams weights, then iacts, to a 1D-conv PE.
module pe_row_feeder #(
  parameter int D_WIDTH    = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_K      = 5,
  parameter int MAX_I      = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [3:0]            kernel_size,
  input  logic [3:0]            iact_size,
  input  logic [ADDR_WIDTH-1:0] weight_base,
  input  logic [ADDR_WIDTH-1:0] iact_base,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [D_WIDTH-1:0]    mem_rdata,
  output logic [D_WIDTH-1:0]    weight_data,
  output logic                  weight_valid,
  input  logic                  weight_ready,
  output logic [D_WIDTH-1:0]    iact_data,
  output logic                  iact_valid,
  input  logic                  iact_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam logic [3:0] MK = 4'(MAX_K);
  localparam logic [3:0] MI = 4'(MAX_I);

  typedef enum logic [1:0] {
    IDLE, WGT, ACT, DONE
  } state_t;

  state_t state, state_nx;

  logic [3:0]            k_q, i_q;
  logic [3:0]            rd_cnt, acc_cnt;
  logic [ADDR_WIDTH-1:0] wb_q, ib_q;
  logic                  pend;
  logic [1:0]            occ;
  logic [D_WIDTH-1:0]    head, tail;
  logic [D_WIDTH-1:0]    w_hold, i_hold;
  logic                  err_q;

  logic                  bad;
  logic                  act;
  logic [3:0]            n;
  logic [ADDR_WIDTH-1:0] base;
  logic                  vld, rdy, pop, last, issue;
  logic [2:0]            fill;

  // Size legality and per-cycle datapath control
  always_comb begin
    bad = (kernel_size == 4'd0) || (iact_size == 4'd0)
       || (kernel_size > iact_size)
       || (kernel_size > MK) || (iact_size > MI);
    act  = (state == WGT) || (state == ACT);
    n    = (state == WGT) ? k_q : i_q;
    base = (state == WGT) ? wb_q : ib_q;
    rdy  = (state == WGT) ? weight_ready : iact_ready;
    vld  = act && (occ != 2'd0);
    pop  = vld && rdy;
    last = pop && (acc_cnt == n - 4'd1);
    fill = {1'b0, occ} + {2'b0, pend};
    issue = act && (rd_cnt < n)
         && (fill < (pop ? 3'd3 : 3'd2));
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start && !bad) state_nx = WGT;
      WGT:  if (last) state_nx = ACT;
      ACT:  if (last) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy         = act;
    done         = (state == DONE);
    err          = err_q;
    weight_valid = (state == WGT) && (occ != 2'd0);
    iact_valid   = (state == ACT) && (occ != 2'd0);
    weight_data  = (state == WGT) ? head : w_hold;
    iact_data    = (state == ACT) ? head : i_hold;
    mem_rd_en    = issue;
    mem_addr     = issue ? base + ADDR_WIDTH'(rd_cnt) : '0;
  end

  // Transfer parameters captured on start; err flags a rejected start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q   <= '0;
      i_q   <= '0;
      wb_q  <= '0;
      ib_q  <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= (state == IDLE) && start && bad;
      if ((state == IDLE) && start) begin
        k_q  <= kernel_size;
        i_q  <= iact_size;
        wb_q <= weight_base;
        ib_q <= iact_base;
      end
    end
  end

  // Per-phase read and accept counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt  <= '0;
      acc_cnt <= '0;
    end else if (!act || last) begin
      rd_cnt  <= '0;
      acc_cnt <= '0;
    end else begin
      rd_cnt  <= rd_cnt + {3'b0, issue};
      acc_cnt <= acc_cnt + {3'b0, pop};
    end
  end

  // Read-in-flight flag and 2-entry skid FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= 1'b0;
      occ  <= '0;
      head <= '0;
      tail <= '0;
    end else begin
      pend <= issue;
      unique case ({pend, pop})
        2'b10: begin
          if (occ == 2'd0) head <= mem_rdata;
          else             tail <= mem_rdata;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          head <= tail;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            head <= mem_rdata;
          end else begin
            head <= tail;
            tail <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // Inactive stream keeps showing its last word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_hold <= '0;
      i_hold <= '0;
    end else begin
      if (state == WGT) w_hold <= head;
      if (state == ACT) i_hold <= head;
    end
  end

endmodule

// File: tb/tb_pe_row_feeder.sv
// tb_pe_row_feeder: random and directed transfers checked against
// a queue-based model of the expected address and data streams.
module tb_pe_row_feeder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  kernel_size = '0;
  logic [3:0]  iact_size = '0;
  logic [7:0]  weight_base = '0;
  logic [7:0]  iact_base = '0;
  logic        mem_rd_en;
  logic [7:0]  mem_addr;
  logic [31:0] mem_rdata = '0;
  logic [31:0] weight_data;
  logic        weight_valid;
  logic        weight_ready = 1'b1;
  logic [31:0] iact_data;
  logic        iact_valid;
  logic        iact_ready = 1'b1;
  logic        busy, done, err;

  pe_row_feeder dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .kernel_size(kernel_size), .iact_size(iact_size),
    .weight_base(weight_base), .iact_base(iact_base),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata),
    .weight_data(weight_data), .weight_valid(weight_valid),
    .weight_ready(weight_ready),
    .iact_data(iact_data), .iact_valid(iact_valid),
    .iact_ready(iact_ready),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [256];
  logic [31:0] exp_w[$];
  logic [31:0] exp_i[$];
  logic [7:0]  exp_a[$];
  int n_chk = 0;
  int n_pass = 0;
  int rd_total = 0;
  int hs_total = 0;
  int i_hs = 0;
  int wv_cyc = 0;
  int iv_cyc = 0;
  int rmode = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Scratchpad: one-cycle read latency
  always @(posedge clk)
    if (mem_rd_en) mem_rdata <= mem[mem_addr];

  // Ready pattern, changed just after each edge
  always @(posedge clk) begin
    #1;
    case (rmode)
      0: begin weight_ready = 1'b1; iact_ready = 1'b1; end
      1: begin weight_ready = ~weight_ready; iact_ready = ~iact_ready; end
      default: begin
        weight_ready = 1'($urandom_range(0, 1));
        iact_ready   = 1'($urandom_range(0, 1));
      end
    endcase
  end

  logic        pwv = 0, pwr = 0, piv = 0, pir = 0;
  logic [31:0] pwd = 0, pid = 0;

  // Stream monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      pwv = 0; piv = 0;
    end else begin
      if (mem_rd_en) begin
        rd_total++;
        if (exp_a.size() == 0) chk("rd_extra", 1, 0);
        else chk("addr", mem_addr, exp_a.pop_front());
      end
      if (weight_valid) wv_cyc++;
      if (iact_valid) iv_cyc++;
      chk("one_valid", weight_valid && iact_valid, 0);
      chk("iact_early", iact_valid && (exp_w.size() != 0), 0);
      if (pwv && !pwr) begin
        chk("w_hold_vld", weight_valid, 1);
        chk("w_stable", weight_data, pwd);
      end
      if (piv && !pir) begin
        chk("i_hold_vld", iact_valid, 1);
        chk("i_stable", iact_data, pid);
      end
      if (weight_valid && weight_ready) begin
        hs_total++;
        if (exp_w.size() == 0) chk("w_extra", 1, 0);
        else chk("wdata", weight_data, exp_w.pop_front());
      end
      if (iact_valid && iact_ready) begin
        hs_total++;
        i_hs++;
        if (exp_i.size() == 0) chk("i_extra", 1, 0);
        else chk("idata", iact_data, exp_i.pop_front());
      end
      chk("outstanding", (rd_total - hs_total) <= 2, 1);
      pwv = weight_valid; pwr = weight_ready; pwd = weight_data;
      piv = iact_valid;   pir = iact_ready;   pid = iact_data;
    end
  end

  task automatic load_exp(int k, int i, logic [7:0] wb,
                          logic [7:0] ib);
    logic [7:0] a;
    for (int j = 0; j < k; j++) begin
      a = wb + 8'(j);
      exp_w.push_back(mem[a]);
      exp_a.push_back(a);
    end
    for (int j = 0; j < i; j++) begin
      a = ib + 8'(j);
      exp_i.push_back(mem[a]);
      exp_a.push_back(a);
    end
  endtask

  task automatic pulse_start(int k, int i, logic [7:0] wb,
                             logic [7:0] ib);
    @(negedge clk);
    kernel_size = 4'(k); iact_size = 4'(i);
    weight_base = wb;    iact_base = ib;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_xfer(int k, int i, logic [7:0] wb,
                          logic [7:0] ib, int mode, bit restart);
    bit seen = 0;
    bit sent = 0;
    int nb = 0;
    int extra = 0;
    rmode = mode;
    load_exp(k, i, wb, ib);
    wv_cyc = 0; iv_cyc = 0;
    pulse_start(k, i, wb, ib);
    for (int c = 0; c < 400 && !seen; c++) begin
      if (start) start = 1'b0;
      if (done) begin
        seen = 1;
        chk("busy_at_done", busy, 0);
      end else begin
        if (!busy) nb++;
        if (restart && !sent && iact_valid) begin
          kernel_size = 4'd1; iact_size = 4'd1;
          weight_base = ~wb;  iact_base = ~ib;
          start = 1'b1;
          sent = 1;
        end
      end
      if (!seen) @(negedge clk);
    end
    start = 1'b0;
    chk("done_seen", seen, 1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done) extra++;
    end
    chk("done_once", extra, 0);
    chk("busy_hi", nb, 0);
    chk("busy_after", busy, 0);
    chk("w_left", exp_w.size(), 0);
    chk("i_left", exp_i.size(), 0);
    chk("a_left", exp_a.size(), 0);
    if (mode == 0) begin
      chk("w_cycles", wv_cyc, k);
      chk("i_cycles", iv_cyc, i);
    end
  endtask

  task automatic err_case(int k, int i);
    int r0 = rd_total;
    int e = 0;
    int b = 0;
    pulse_start(k, i, 8'h40, 8'h50);
    if (err) e++;
    for (int c = 0; c < 4; c++) begin
      if (busy) b++;
      @(negedge clk);
      if (err) e++;
    end
    chk("err_pulse", e, 1);
    chk("err_no_rd", rd_total - r0, 0);
    chk("err_busy", b, 0);
  endtask

  initial begin
    int k, i;
    for (int a = 0; a < 256; a++) mem[a] = $urandom;
    for (int j = 0; j < 3; j++) mem[8'h10 + j] = 32'(j + 1);
    for (int j = 0; j < 5; j++) mem[8'h20 + j] = 32'(j + 4);

    #12;
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_wv", weight_valid, 0);
    chk("rst_iv", iact_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_wdata", weight_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_xfer(3, 5, 8'h10, 8'h20, 0, 0);
    run_xfer(3, 5, 8'h10, 8'h20, 1, 0);

    err_case(4, 3);
    err_case(0, 3);
    err_case(3, 7);
    err_case(6, 6);

    run_xfer(2, 4, 8'h30, 8'hFE, 0, 0);
    run_xfer(3, 5, 8'h10, 8'h20, 2, 1);

    for (int t = 0; t < 10; t++) begin
      i = $urandom_range(1, 6);
      k = $urandom_range(1, (i < 5) ? i : 5);
      run_xfer(k, i, 8'($urandom), 8'($urandom), 2, t[0]);
    end

    rmode = 0;
    i_hs = 0;
    load_exp(2, 5, 8'h60, 8'h70);
    pulse_start(2, 5, 8'h60, 8'h70);
    for (int c = 0; c < 100 && i_hs < 2; c++) @(negedge clk);
    chk("mid_reached", i_hs >= 2, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rd_en", mem_rd_en, 0);
    chk("mid_addr", mem_addr, 0);
    chk("mid_wv", weight_valid, 0);
    chk("mid_iv", iact_valid, 0);
    chk("mid_wdata", weight_data, 0);
    chk("mid_idata", iact_data, 0);
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    chk("mid_err", err, 0);
    exp_w.delete(); exp_i.delete(); exp_a.delete();
    rd_total = 0; hs_total = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_busy", busy, 0);
    run_xfer(1, 1, 8'h80, 8'h90, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
